// File: rtl/obf_seq_gen.sv
// Substitution sequencer behind the instruction group unit: replaces each fetched
// instruction by its original word or a 1..7-word micro-sequence from a loadable store.
module obf_seq_gen #(
    parameter int IDX_W  = 7,
    parameter int ADDR_W = 6
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         en_i,
    input  logic                                         flush_i,
    input  logic                                         in_valid_i,
    output logic                                         in_ready_o,
    input  logic [31:0]                                  insn_i,
    input  logic [IDX_W-1:0]                             idx_i,
    output logic                                         out_valid_o,
    input  logic                                         out_ready_i,
    output logic [31:0]                                  out_insn_o,
    output logic                                         out_last_o,
    output logic                                         out_illegal_o,
    input  logic                                         cfg_we_i,
    input  logic                                         cfg_sel_i,
    input  logic [((IDX_W > ADDR_W) ? IDX_W : ADDR_W)-1:0] cfg_addr_i,
    input  logic [34:0]                                  cfg_wdata_i
);

    localparam int DESC_DEPTH = 1 << IDX_W;
    localparam int UOP_DEPTH  = 1 << ADDR_W;
    localparam int DESC_W     = ADDR_W + 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [2:0]          cnt_reg, cnt_next;
    logic [2:0]          len_reg, len_next;
    logic [ADDR_W-1:0]   base_reg, base_next;
    logic [31:0]         insn_reg, insn_next;
    logic                out_valid_reg, out_valid_next;
    logic                out_last_reg, out_last_next;
    logic                out_illegal_reg, out_illegal_next;
    logic [31:0]         out_insn_reg, out_insn_next;

    logic                desc_we;
    logic                uop_we;
    logic [DESC_DEPTH-1:0][DESC_W-1:0] desc_q;
    logic [34:0]         uop_mem [UOP_DEPTH];

    logic [DESC_W-1:0]   desc_sel;
    logic [2:0]          desc_len;
    logic [ADDR_W-1:0]   desc_base;
    logic                idx_illegal;
    logic                bypass;
    logic                out_free;
    logic                accept;
    logic                emit_last;
    logic [ADDR_W-1:0]   uop_addr;
    logic [34:0]         uop_word;
    logic [31:0]         src_insn;
    logic [31:0]         subst_word;

    assign desc_we = cfg_we_i && !cfg_sel_i;
    assign uop_we  = cfg_we_i && cfg_sel_i;

    // Descriptors reset to zero (pass-through), so each entry is its own register.
    generate
        for (genvar gi = 0; gi < DESC_DEPTH; gi++) begin : g_desc
            logic [DESC_W-1:0] entry_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (desc_we && (cfg_addr_i[IDX_W-1:0] == IDX_W'(gi))) begin
                    entry_reg <= cfg_wdata_i[DESC_W-1:0];
                end
            end
            assign desc_q[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (uop_we) begin
            uop_mem[cfg_addr_i[ADDR_W-1:0]] <= cfg_wdata_i;
        end
    end

    assign desc_sel    = desc_q[idx_i];
    assign desc_len    = desc_sel[2:0];
    assign desc_base   = desc_sel[DESC_W-1:3];
    assign idx_illegal = &idx_i;
    assign bypass      = !en_i || idx_illegal || (desc_len == 3'd0);

    assign out_free   = !out_valid_reg || out_ready_i;
    assign in_ready_o = (state_reg == IDLE) && out_free && !flush_i;
    assign accept     = in_valid_i && in_ready_o;
    assign emit_last  = (cnt_reg == (len_reg - 3'd1));

    // In EMIT the sequence runs from captured state; in IDLE it starts from live inputs.
    assign uop_addr = (state_reg == EMIT) ? (base_reg + ADDR_W'(cnt_reg)) : desc_base;
    assign uop_word = uop_mem[uop_addr];
    assign src_insn = (state_reg == EMIT) ? insn_reg : insn_i;

    always_comb begin
        subst_word = uop_word[31:0];
        if (uop_word[34]) subst_word[25:21] = src_insn[25:21];
        if (uop_word[33]) subst_word[20:16] = src_insn[20:16];
        if (uop_word[32]) subst_word[15:11] = src_insn[15:11];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: if (accept && !bypass && (desc_len > 3'd1)) state_next = EMIT;
                EMIT: if (out_ready_i && emit_last) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_next         = cnt_reg;
        len_next         = len_reg;
        base_next        = base_reg;
        insn_next        = insn_reg;
        out_valid_next   = out_valid_reg;
        out_last_next    = out_last_reg;
        out_illegal_next = out_illegal_reg;
        out_insn_next    = out_insn_reg;
        if (flush_i) begin
            cnt_next       = 3'd0;
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        insn_next      = insn_i;
                        len_next       = desc_len;
                        base_next      = desc_base;
                        out_valid_next = 1'b1;
                        if (bypass) begin
                            out_insn_next    = insn_i;
                            out_last_next    = 1'b1;
                            out_illegal_next = idx_illegal;
                        end else begin
                            out_insn_next    = subst_word;
                            out_last_next    = (desc_len == 3'd1);
                            out_illegal_next = 1'b0;
                            cnt_next         = 3'd1;
                        end
                    end else if (out_ready_i) begin
                        out_valid_next = 1'b0;
                    end
                end
                EMIT: begin
                    if (out_ready_i) begin
                        out_insn_next    = subst_word;
                        out_last_next    = emit_last;
                        out_illegal_next = 1'b0;
                        out_valid_next   = 1'b1;
                        cnt_next         = cnt_reg + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg         <= 3'd0;
            len_reg         <= 3'd0;
            base_reg        <= '0;
            insn_reg        <= 32'd0;
            out_valid_reg   <= 1'b0;
            out_last_reg    <= 1'b0;
            out_illegal_reg <= 1'b0;
            out_insn_reg    <= 32'd0;
        end else begin
            cnt_reg         <= cnt_next;
            len_reg         <= len_next;
            base_reg        <= base_next;
            insn_reg        <= insn_next;
            out_valid_reg   <= out_valid_next;
            out_last_reg    <= out_last_next;
            out_illegal_reg <= out_illegal_next;
            out_insn_reg    <= out_insn_next;
        end
    end

    assign out_valid_o   = out_valid_reg;
    assign out_last_o    = out_last_reg;
    assign out_illegal_o = out_illegal_reg;
    assign out_insn_o    = out_insn_reg;

endmodule
